dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port request/acknowledge arbiter in front of `data_memory`. It shares the single data memory between the core load/store port (port 0) and an auxiliary port (port 1, used by the program loader and debug access). Each access is latched, checked for alignment, driven to `data_memory` for exactly one cycle, and answered with a one-cycle acknowledge carrying registered read data and an error flag.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width
- `DATA_WIDTH`, 32, data width; fixed at 32 for word/half/byte semantics

Ports, with `x` ∈ {0,1}:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_x`  in  1  access request; held high until `ack_x`
- `addr_x`  in  ADDR_WIDTH  byte address
- `wdata_x`  in  DATA_WIDTH  store data, LSB-aligned
- `we_x`  in  1  1 = store, 0 = load
- `ls_type_x`  in  2  `LS_BYTE`/`LS_HALF`/`LS_WORD` from `controls.sv`; 2'b11 reserved
- `unsigned_x`  in  1  zero-extend load
- `ack_x`  out  1  one-cycle completion pulse
- `rdata`  out  DATA_WIDTH  load result; valid while either ack is high
- `err`  out  1  misaligned or reserved-type access; valid with ack
- `mem_address`, `mem_write_data`  out  ADDR_WIDTH/DATA_WIDTH  to `data_memory`
- `mem_read`, `mem_write`  out  1  to `data_memory`
- `mem_load_store_type`  out  2  to `data_memory`
- `mem_load_unsigned`  out  1  to `data_memory`
- `mem_read_data`  in  DATA_WIDTH  from `data_memory`, combinational read

## Operation
FSM states:
- IDLE
  - With no request pending, stay in IDLE.
  - With any `req_x` high, pick a winner (see Configuration). Latch its addr, wdata, we, ls_type, unsigned, and port ID. Compute `mis` from the latched fields: half with addr[0]=1, word with addr[1:0]≠0, or ls_type = 2'b11. Go to ACCESS.
- ACCESS
  - Drive `mem_*` from the latched fields.
  - `mem_write` = we & ~mis; `mem_read` = ~we & ~mis.
  - At the closing edge: `data_memory` commits the store; `rdata` ← (load & ~mis) ? `mem_read_data` : 0; `err` ← mis. Go to RESP.
- RESP
  - `ack` of the latched port = 1 for this single cycle. Go to IDLE.
  - The request is not re-sampled in RESP. A `req_x` still high in the following IDLE cycle is a new request.

General rules:
- Outside ACCESS, all `mem_*` outputs are 0.
- `rdata` and `err` hold their values until the next ACCESS edge.
- A misaligned store never reaches memory.
- A misaligned load returns `rdata` = 0 and `err` = 1.
- Only one access is in flight; the losing requester keeps waiting with `req` high.

## Timing
- Reset values: state = IDLE, `ack_0` = `ack_1` = 0, `rdata` = 0, `err` = 0, all `mem_*` = 0, round-robin pointer favours port 0.
- Latency: request sampled in IDLE at edge N, ACCESS in cycle N+1, `ack` in cycle N+2. That is 2 cycles from the sampling edge to ack.
- Throughput: one access per 3 cycles.
- Back-to-back requests from both ports complete in 6 cycles.
- Reset during ACCESS:
  - `mem_write` is already asserted in that cycle, so the store commits at the reset edge.
  - No ack is issued, and `rdata`/`err` are reset to 0.
- Reset during RESP: the ack in that cycle is still visible; all state clears at the edge.
- Requesters must hold addr/wdata/we/ls_type/unsigned stable only until the sampling edge. The arbiter works from latched copies after that.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a simultaneous request, the winner is the port not granted last.
  - The pointer updates on each grant and resets to "port 1 last", so port 0 wins the first tie.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. Port 1 can starve under continuous port-0 traffic.

## Test plan
- Port 0 stores word 0xF0F0F0F0 at 0x1C, then loads word at 0x1C → `ack_0` 2 cycles after each sampling edge, `rdata` = 0xF0F0F0F0, `err` = 0.
- Port 1 stores byte 0xF0 at 0x16, then loads byte at 0x16 signed and unsigned → `rdata` = 0xFFFFFFF0 and 0x000000F0; load word at 0x14 → 0x00F00000.
- Port 0 loads half at 0x09 and word at 0x1D; store word 0x12345678 at 0x1D → `err` = 1, `rdata` = 0, `mem_read`/`mem_write` never asserted, memory at 0x1C unchanged.
- Both ports request continuously:
  - With `DMEM_ARB_RR_EN`: acks alternate 0,1,0,1 every 3 cycles.
  - Without it: only `ack_0` fires.
- `rst` asserted during ACCESS of a port-1 store → store visible on a later read, `ack_1` never pulses, all outputs 0 the next cycle.
- `ls_type` = 2'b11 load from port 1 → `err` = 1, `rdata` = 0, `ack_1` pulse.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_memory between core port 0 and aux port 1 through an IDLE/ACCESS/RESP FSM.
// Optional feature macro DMEM_ARB_RR_EN selects round-robin tie-break; default is fixed priority to port 0.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic                  we_0,
    input  logic [1:0]            ls_type_0,
    input  logic                  unsigned_0,
    input  logic                  req_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    input  logic                  we_1,
    input  logic [1:0]            ls_type_1,
    input  logic                  unsigned_1,
    output logic                  ack_0,
    output logic                  ack_1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mem_load_store_type,
    output logic                  mem_load_unsigned,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    // Encodings shared with controls.sv: 00 byte, 01 half, 10 word, 11 reserved.
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;
    localparam logic [1:0] LS_RSVD = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [1:0]            type_q;
    logic                  uns_q;
    logic                  port_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  win;
    logic                  take;
    logic                  mis;

    assign take = (state_q == S_IDLE) && (req_0 || req_1);

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= win;
        end
    end

    always_comb begin
        win = (req_0 && req_1) ? ~last_q : req_1;
    end
`else
    always_comb begin
        win = ~req_0;
    end
`endif

    assign mis = ((type_q == LS_HALF) && addr_q[0])
              || ((type_q == LS_WORD) && (addr_q[1:0] != 2'b00))
              || (type_q == LS_RSVD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            type_q  <= 2'b00;
            uns_q   <= 1'b0;
            port_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                port_q  <= win;
                addr_q  <= win ? addr_1     : addr_0;
                wdata_q <= win ? wdata_1    : wdata_0;
                we_q    <= win ? we_1       : we_0;
                type_q  <= win ? ls_type_1  : ls_type_0;
                uns_q   <= win ? unsigned_1 : unsigned_0;
            end
            if (state_q == S_ACCESS) begin
                rdata_q <= (!we_q && !mis) ? mem_read_data : '0;
                err_q   <= mis;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_0 || req_1) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_0               = 1'b0;
        ack_1               = 1'b0;
        mem_address         = '0;
        mem_write_data      = '0;
        mem_read            = 1'b0;
        mem_write           = 1'b0;
        mem_load_store_type = 2'b00;
        mem_load_unsigned   = 1'b0;
        case (state_q)
            S_ACCESS: begin
                mem_address         = addr_q;
                mem_write_data      = wdata_q;
                mem_read            = ~we_q & ~mis;
                mem_write           = we_q & ~mis;
                mem_load_store_type = type_q;
                mem_load_unsigned   = uns_q;
            end
            S_RESP: begin
                ack_0 = ~port_q;
                ack_1 = port_q;
            end
            default: ;
        endcase
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter with a transaction-level model and a byte-array data_memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req_0, req_1, we_0, we_1, unsigned_0, unsigned_1;
    logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
    logic [1:0]  ls_type_0, ls_type_1;
    logic        ack_0, ack_1, err;
    logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write, mem_load_unsigned;
    logic [1:0]  mem_load_store_type;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .addr_0(addr_0), .wdata_0(wdata_0), .we_0(we_0),
        .ls_type_0(ls_type_0), .unsigned_0(unsigned_0),
        .req_1(req_1), .addr_1(addr_1), .wdata_1(wdata_1), .we_1(we_1),
        .ls_type_1(ls_type_1), .unsigned_1(unsigned_1),
        .ack_0(ack_0), .ack_1(ack_1), .rdata(rdata), .err(err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_load_store_type(mem_load_store_type), .mem_load_unsigned(mem_load_unsigned),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef logic [7:0] mem_t [256];
    typedef struct {
        logic        we;
        logic [1:0]  t;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
    } rq_t;

    mem_t phys   = '{default: 8'h00};
    mem_t shadow = '{default: 8'h00};

    function automatic logic [31:0] ld(input mem_t m, input logic [31:0] addr,
                                       input logic [1:0] t, input logic u);
        logic [7:0] a;
        a = addr[7:0];
        case (t)
            2'b00:   ld = u ? {24'h0, m[a]} : {{24{m[a][7]}}, m[a]};
            2'b01:   ld = u ? {16'h0, m[a+8'd1], m[a]} : {{16{m[a+8'd1][7]}}, m[a+8'd1], m[a]};
            default: ld = {m[a+8'd3], m[a+8'd2], m[a+8'd1], m[a]};
        endcase
    endfunction

    // Little-endian data_memory: combinational read, store on rising edge.
    always_comb mem_read_data = ld(phys, mem_address, mem_load_store_type, mem_load_unsigned);

    always @(posedge clk) begin
        if (mem_write) begin
            phys[mem_address[7:0]] <= mem_write_data[7:0];
            if (mem_load_store_type != 2'b00)
                phys[mem_address[7:0]+8'd1] <= mem_write_data[15:8];
            if (mem_load_store_type[1]) begin
                phys[mem_address[7:0]+8'd2] <= mem_write_data[23:16];
                phys[mem_address[7:0]+8'd3] <= mem_write_data[31:24];
            end
        end
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    rq_t         q0[$], q1[$];
    rq_t         cur [2];
    bit          active [2];
    bit          granted [2];
    rq_t         t;
    int          t_port, t_g;
    bit          have_txn;
    logic        t_mis;
    logic [31:0] t_res;
    int          free_cyc;
    int          last_p;
    logic [31:0] cur_rdata;
    logic        cur_err;
    logic [31:0] ack_rd [2];
    logic        ack_er [2];
    int          n_ack [2];
    int          ack_seq[$];
    int          n_memrw;
    bit          rst_plan, rst_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic rq_t mk(input logic we, input logic [1:0] tt, input logic u,
                               input logic [31:0] a, input logic [31:0] d);
        rq_t r;
        r.we = we; r.t = tt; r.u = u; r.a = a; r.d = d;
        return r;
    endfunction

    function automatic rq_t rnd_rq();
        rq_t r;
        r.we = 1'($urandom_range(0, 1));
        r.t  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r.u  = 1'($urandom_range(0, 1));
        r.a  = $urandom;
        r.d  = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (r.t == 2'b01) r.a[0] = 1'b0;
            if (r.t == 2'b10) r.a[1:0] = 2'b00;
        end
        return r;
    endfunction

    function automatic logic misaligned(input rq_t r);
        return (r.t == 2'b11) || (r.t == 2'b01 && r.a[0]) || (r.t == 2'b10 && r.a[1:0] != 2'b00);
    endfunction

    task automatic grant(input int w);
        t = cur[w];
        t_port = w;
        t_g = cyc;
        t_mis = misaligned(t);
        t_res = (!t.we && !t_mis) ? ld(shadow, t.a, t.t, t.u) : 32'h0;
        if (t.we && !t_mis) begin
            shadow[t.a[7:0]] = t.d[7:0];
            if (t.t != 2'b00) shadow[t.a[7:0]+8'd1] = t.d[15:8];
            if (t.t[1]) begin
                shadow[t.a[7:0]+8'd2] = t.d[23:16];
                shadow[t.a[7:0]+8'd3] = t.d[31:24];
            end
        end
        have_txn = 1'b1;
        free_cyc = cyc + 3;
        last_p = w;
        granted[w] = 1'b1;
    endtask

    task automatic drive();
        req_0 = active[0];
        req_1 = active[1];
        if (active[0] && !granted[0]) begin
            addr_0 = cur[0].a; wdata_0 = cur[0].d; we_0 = cur[0].we;
            ls_type_0 = cur[0].t; unsigned_0 = cur[0].u;
        end else begin
            addr_0 = $urandom; wdata_0 = $urandom; we_0 = 1'($urandom_range(0, 1));
            ls_type_0 = 2'($urandom_range(0, 3)); unsigned_0 = 1'($urandom_range(0, 1));
        end
        if (active[1] && !granted[1]) begin
            addr_1 = cur[1].a; wdata_1 = cur[1].d; we_1 = cur[1].we;
            ls_type_1 = cur[1].t; unsigned_1 = cur[1].u;
        end else begin
            addr_1 = $urandom; wdata_1 = $urandom; we_1 = 1'($urandom_range(0, 1));
            ls_type_1 = 2'($urandom_range(0, 3)); unsigned_1 = 1'($urandom_range(0, 1));
        end
    endtask

    // One cycle: compare DUT against the model, then choose inputs for the coming edge.
    task automatic step();
        bit in_acc, in_resp;
        @(negedge clk);
        cyc++;
        in_acc  = have_txn && (cyc == t_g + 1);
        in_resp = have_txn && (cyc == t_g + 2);
        if (in_resp) begin
            cur_rdata = t_res;
            cur_err   = t_mis;
        end
        chk("ack_0", 32'(ack_0), 32'(in_resp && t_port == 0));
        chk("ack_1", 32'(ack_1), 32'(in_resp && t_port == 1));
        chk("rdata", rdata, cur_rdata);
        chk("err", 32'(err), 32'(cur_err));
        chk("mem_read", 32'(mem_read), 32'(in_acc && !t.we && !t_mis));
        chk("mem_write", 32'(mem_write), 32'(in_acc && t.we && !t_mis));
        chk("mem_address", mem_address, in_acc ? t.a : 32'h0);
        chk("mem_write_data", mem_write_data, in_acc ? t.d : 32'h0);
        chk("mem_ls_type", 32'(mem_load_store_type), in_acc ? 32'(t.t) : 32'h0);
        chk("mem_unsigned", 32'(mem_load_unsigned), in_acc ? 32'(t.u) : 32'h0);
        if (ack_0) begin ack_rd[0] = rdata; ack_er[0] = err; n_ack[0]++; ack_seq.push_back(0); end
        if (ack_1) begin ack_rd[1] = rdata; ack_er[1] = err; n_ack[1]++; ack_seq.push_back(1); end
        if (mem_read || mem_write) n_memrw++;
        if (in_resp) begin
            have_txn = 1'b0;
            active[t_port] = 1'b0;
            granted[t_port] = 1'b0;
        end
        if (rst_plan && in_acc && t_port == 1 && t.we) begin
            rst = 1'b1;
            rst_plan = 1'b0;
            rst_done = 1'b1;
            have_txn = 1'b0;
            active[0] = 1'b0; active[1] = 1'b0;
            granted[0] = 1'b0; granted[1] = 1'b0;
            cur_rdata = 32'h0;
            cur_err = 1'b0;
            last_p = 1;
            free_cyc = cyc + 1;
            req_0 = 1'b0;
            req_1 = 1'b0;
            return;
        end
        rst = 1'b0;
        if (!active[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); active[0] = 1'b1; end
        if (!active[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); active[1] = 1'b1; end
        drive();
        if (!have_txn && cyc >= free_cyc && (active[0] || active[1])) begin
            if (active[0] && active[1]) grant(RR ? 1 - last_p : 0);
            else grant(active[0] ? 0 : 1);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || active[0] || active[1] || have_txn) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
        end
    endtask

    task automatic do1(input int p, input rq_t r);
        if (p == 0) q0.push_back(r);
        else q1.push_back(r);
        wait_idle(50);
    endtask

    initial begin
        int n1_before, n;
        rst = 1'b1;
        active[0] = 1'b0; active[1] = 1'b0;
        granted[0] = 1'b0; granted[1] = 1'b0;
        n_ack[0] = 0; n_ack[1] = 0;
        have_txn = 1'b0; free_cyc = 0; last_p = 1;
        cur_rdata = 32'h0; cur_err = 1'b0;
        rst_plan = 1'b0; rst_done = 1'b0; n_memrw = 0;
        drive();
        repeat (3) @(negedge clk);
        chk("rst_ack_0", 32'(ack_0), 32'h0);
        chk("rst_ack_1", 32'(ack_1), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_mem_rw", 32'({mem_read, mem_write}), 32'h0);
        chk("rst_mem_addr", mem_address, 32'h0);
        rst = 1'b0;

        do1(0, mk(1'b1, 2'b10, 1'b0, 32'h1C, 32'hF0F0F0F0));
        chk("lit_st_w_err", 32'(ack_er[0]), 32'h0);
        do1(0, mk(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0));
        chk("lit_ld_w", ack_rd[0], 32'hF0F0F0F0);
        chk("lit_ld_w_err", 32'(ack_er[0]), 32'h0);

        do1(1, mk(1'b1, 2'b00, 1'b0, 32'h16, 32'hABCDEFF0));
        do1(1, mk(1'b0, 2'b00, 1'b0, 32'h16, 32'h0));
        chk("lit_ld_b_s", ack_rd[1], 32'hFFFFFFF0);
        do1(1, mk(1'b0, 2'b00, 1'b1, 32'h16, 32'h0));
        chk("lit_ld_b_u", ack_rd[1], 32'h000000F0);
        do1(1, mk(1'b0, 2'b10, 1'b0, 32'h14, 32'h0));
        chk("lit_ld_w14", ack_rd[1], 32'h00F00000);

        n_memrw = 0;
        do1(0, mk(1'b0, 2'b01, 1'b0, 32'h09, 32'h0));
        chk("lit_mis_h_rd", ack_rd[0], 32'h0);
        chk("lit_mis_h_err", 32'(ack_er[0]), 32'h1);
        do1(0, mk(1'b0, 2'b10, 1'b0, 32'h1D, 32'h0));
        chk("lit_mis_w_err", 32'(ack_er[0]), 32'h1);
        do1(0, mk(1'b1, 2'b10, 1'b0, 32'h1D, 32'h12345678));
        chk("lit_mis_st_err", 32'(ack_er[0]), 32'h1);
        chk("lit_mis_no_memrw", 32'(n_memrw), 32'h0);
        do1(0, mk(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0));
        chk("lit_1c_unchanged", ack_rd[0], 32'hF0F0F0F0);

        n1_before = n_ack[1];
        do1(1, mk(1'b0, 2'b11, 1'b0, 32'h20, 32'h0));
        chk("lit_rsvd_err", 32'(ack_er[1]), 32'h1);
        chk("lit_rsvd_rd", ack_rd[1], 32'h0);
        chk("lit_rsvd_ack", 32'(n_ack[1] - n1_before), 32'h1);

        // Reset lands in the ACCESS cycle of a port-1 store.
        n1_before = n_ack[1];
        rst_plan = 1'b1;
        q1.push_back(mk(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEBABE));
        n = 0;
        while (!rst_done && n < 20) begin step(); n++; end
        if (!rst_done) begin
            n_chk++; n_fail++;
            $display("FAIL rst_access: reset point not reached, required within 20 cycles");
        end
        step();
        chk("lit_rst_ack_1", 32'(ack_1), 32'h0);
        chk("lit_rst_rdata", rdata, 32'h0);
        chk("lit_rst_err", 32'(err), 32'h0);
        chk("lit_rst_mem_write", 32'(mem_write), 32'h0);
        repeat (4) step();
        chk("lit_rst_no_ack", 32'(n_ack[1] - n1_before), 32'h0);
        do1(1, mk(1'b0, 2'b10, 1'b0, 32'h40, 32'h0));
        chk("lit_rst_store_kept", ack_rd[1], 32'hCAFEBABE);

        // Both ports requesting continuously.
        ack_seq.delete();
        for (int i = 0; i < 12; i++) begin
            q0.push_back(mk(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0));
            q1.push_back(mk(1'b0, 2'b10, 1'b1, 32'(64 + i * 4), 32'h0));
        end
        repeat (24) step();
        chk("cont_ack_count", 32'(ack_seq.size()), 32'd8);
`ifdef DMEM_ARB_RR_EN
        for (int i = 1; i < ack_seq.size(); i++)
            chk("rr_alternate", 32'(ack_seq[i]), 32'(1 - ack_seq[i-1]));
`else
        for (int i = 0; i < ack_seq.size(); i++)
            chk("fixed_port0_only", 32'(ack_seq[i]), 32'h0);
`endif
        wait_idle(200);

        for (int i = 0; i < 3000; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rnd_rq());
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rnd_rq());
            step();
        end
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
